// File: rtl/pipe_stage_if.sv
// Handshake/payload bundle between a feeding stage and its pipe_stage_reg.
interface pipe_stage_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned EXC_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              en;
  logic              clr;
  logic              flush;
  logic              cnt_clr;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic [PC_W-1:0]   pc_in;
  logic              bd_in;
  logic [EXC_W-1:0]  exc_in;
  logic [EXC_W-1:0]  local_exc;

  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic [PC_W-1:0]   pc_out;
  logic [PC_W-1:0]   pc4_out;
  logic              bd_out;
  logic [EXC_W-1:0]  exc_out;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output en, clr, flush, cnt_clr, valid_in, data_in, pc_in, bd_in, exc_in, local_exc,
    input  valid_out, data_out, pc_out, pc4_out, bd_out, exc_out, stall_cnt, bubble_cnt
  );

  modport slave (
    input  en, clr, flush, cnt_clr, valid_in, data_in, pc_in, bd_in, exc_in, local_exc,
    output valid_out, data_out, pc_out, pc4_out, bd_out, exc_out, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid bit, exception merge,
// flush/bubble handling and saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       PC_W       = 32,
  parameter int unsigned       EXC_W      = 5,
  parameter logic [PC_W-1:0]   HANDLER_PC = PC_W'(32'h0000_4180),
  parameter int unsigned       CNT_W      = 16
) (
  input logic        clk,
  input logic        reset,
  pipe_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);

  logic             stall_inc;
  logic             bubble_inc;
  logic [EXC_W-1:0] exc_merged;

  // Earliest stage's exception wins; empty slots never carry one.
  always_comb begin
    exc_merged = '0;
    if (bus.valid_in) begin
      exc_merged = (bus.exc_in != '0) ? bus.exc_in : bus.local_exc;
    end
  end

  assign stall_inc  = !bus.flush && !bus.clr && !bus.en && bus.valid_out;
  assign bubble_inc = !bus.flush && bus.clr;

  // Stage contents: reset > flush > clr > load > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.pc_out    <= '0;
      bus.pc4_out   <= '0;
      bus.bd_out    <= 1'b0;
      bus.exc_out   <= '0;
    end else if (bus.flush) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.pc_out    <= HANDLER_PC;
      bus.pc4_out   <= HANDLER_PC + PC_STEP;
      bus.bd_out    <= 1'b0;
      bus.exc_out   <= '0;
    end else if (bus.clr) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.pc_out    <= bus.pc_in;
      bus.pc4_out   <= bus.pc_in + PC_STEP;
      bus.bd_out    <= bus.bd_in;
      bus.exc_out   <= '0;
    end else if (bus.en) begin
      bus.valid_out <= bus.valid_in;
      bus.data_out  <= bus.data_in;
      bus.pc_out    <= bus.pc_in;
      bus.pc4_out   <= bus.pc_in + PC_STEP;
      bus.bd_out    <= bus.bd_in;
      bus.exc_out   <= exc_merged;
    end
  end

  // Saturating counters; cnt_clr beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr) begin
      bus.stall_cnt  <= '0;
      bus.bubble_cnt <= '0;
    end else begin
      if (stall_inc && bus.stall_cnt != CNT_MAX) begin
        bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      end
      if (bubble_inc && bus.bubble_cnt != CNT_MAX) begin
        bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule
